psk_link_ctrl: RTL

// - Runtime sequencer for the PSK Tx/Rx datapath; replaces the fixed config constants.
// - Accepts config requests, drains Tx at a frame boundary, applies new config and flushes Rx.
// - Then waits for sustained Rx_valid lock, runs the link, and re-locks after loss of lock.
// - Sits between host/test logic and the Tx/Rx blocks, in the 16.384 MHz domain.

---
 rtl/psk_link_ctrl_pkg.sv | 37 +++
 rtl/link_lock_det.sv | 57 +++++
 rtl/psk_link_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/psk_link_ctrl_pkg.sv
// rtl/psk_link_ctrl_pkg.sv - shared types and constants for the PSK link sequencer
// Holds the FSM state encoding, cfg_data field layout, reset-default
// configuration shared with the Tx/Rx top, and the frame-boundary helper.
package psk_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_LOCK   = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_APPLY  = 3'd4,
    ST_FAULT  = 3'd5
  } link_state_t;

  // cfg_data = {mode[31:28], delay[27:24], fb[23:20], gd[19:16], phase[15:0]}
  localparam int CFG_NIB_W     = 4;
  localparam int CFG_PHASE_W   = 16;
  localparam int CFG_MODE_LSB  = 28;
  localparam int CFG_DELAY_LSB = 24;
  localparam int CFG_FB_LSB    = 20;
  localparam int CFG_GD_LSB    = 16;
  localparam int CFG_PHASE_LSB = 0;

  localparam logic [3:0]  DEFAULT_MODE     = 4'd4;
  localparam logic [3:0]  DEFAULT_DELAY    = 4'd8;
  localparam logic [3:0]  DEFAULT_FB_SHIFT = 4'd0;
  localparam logic [3:0]  DEFAULT_GD_SHIFT = 4'd3;
  localparam logic [15:0] DEFAULT_TX_PHASE = 16'd8192;

  // A Tx frame boundary is the last beat of a frame, or Tx not busy at all.
  function automatic logic frame_boundary(input logic tx_busy,
                                          input logic beat_valid,
                                          input logic beat_last);
    return (beat_valid & beat_last) | ~tx_busy;
  endfunction

endpackage

// File: rtl/link_lock_det.sv
// rtl/link_lock_det.sv - Rx_valid persistence detector with optional LOCK wait timeout
// Optional feature macro: LINK_CTRL_TIMEOUT_EN (adds the timeout counter).
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clear    in   hold both counters at zero (asserted outside LOCK)
//   rx_valid in   Rx demod valid
//   locked   out  this cycle completes LOCK_CYC consecutive valid cycles
//   timeout  out  LOCK has lasted TIMEOUT_CYC cycles (0 without the macro)
module link_lock_det #(
  parameter int unsigned LOCK_CYC    = 1024
`ifdef LINK_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic rx_valid,
  output logic locked,
  output logic timeout
);

  localparam int LW = $clog2(LOCK_CYC + 1);

  logic [LW-1:0] r_lock_cnt;

  // Count of consecutive valid cycles already seen; any invalid cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst || clear || !rx_valid) begin
      r_lock_cnt <= '0;
    end else if (!locked) begin
      r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  assign locked = rx_valid && (r_lock_cnt == LW'(LOCK_CYC - 1));

`ifdef LINK_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wait_cnt <= '0;
    end else if (!timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign timeout = (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/psk_link_ctrl.sv
// rtl/psk_link_ctrl.sv - runtime config/lock sequencer for the PSK Tx/Rx datapath
// Optional feature macro: LINK_CTRL_TIMEOUT_EN (LOCK timeout -> FAULT).
// Ports:
//   clk_16M384, rst_16M384         clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_data   config request handshake and payload
//   tx_valid, tx_data_tvalid/tlast Tx busy and frame stream (for drain)
//   Rx_valid                       Rx demod valid
//   MODE_CTRL..TX_PHASE_CONFIG     applied configuration
//   tx_enable, rx_flush, link_up   datapath control / status
//   lock_loss_cnt, fault           saturating RUN->LOCK drop count, timeout flag
module psk_link_ctrl
  import psk_link_ctrl_pkg::*;
#(
  parameter logic [3:0]  DEF_MODE     = DEFAULT_MODE,
  parameter logic [3:0]  DEF_DELAY    = DEFAULT_DELAY,
  parameter logic [3:0]  DEF_FB_SHIFT = DEFAULT_FB_SHIFT,
  parameter logic [3:0]  DEF_GD_SHIFT = DEFAULT_GD_SHIFT,
  parameter logic [15:0] DEF_TX_PHASE = DEFAULT_TX_PHASE,
  parameter int unsigned SETTLE_CYC   = 256,
  parameter int unsigned LOCK_CYC     = 1024
`ifdef LINK_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        tx_valid,
  input  logic        tx_data_tvalid,
  input  logic        tx_data_tlast,
  input  logic        Rx_valid,
  output logic [3:0]  MODE_CTRL,
  output logic [3:0]  DELAY_CNT,
  output logic [3:0]  FEEDBACK_SHIFT,
  output logic [3:0]  GARDNER_SHIFT,
  output logic [15:0] TX_PHASE_CONFIG,
  output logic        tx_enable,
  output logic        rx_flush,
  output logic        link_up,
  output logic [7:0]  lock_loss_cnt,
  output logic        fault
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  link_state_t   r_state, w_next;
  logic [SW-1:0] r_settle_cnt;
  logic [31:0]   r_shadow;
  logic [3:0]    r_mode, r_delay, r_fb, r_gd;
  logic [15:0]   r_phase;
  logic [7:0]    r_loss_cnt;
  logic          w_accept, w_settle_done, w_locked, w_timeout;

  link_lock_det #(
    .LOCK_CYC(LOCK_CYC)
`ifdef LINK_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_lock_det (
    .clk     (clk_16M384),
    .rst     (rst_16M384),
    .clear   (r_state != ST_LOCK),
    .rx_valid(Rx_valid),
    .locked  (w_locked),
    .timeout (w_timeout)
  );

  assign cfg_ready     = (r_state == ST_LOCK) || (r_state == ST_RUN) || (r_state == ST_FAULT);
  assign w_accept      = cfg_valid && cfg_ready;
  assign w_settle_done = (r_settle_cnt == SW'(SETTLE_CYC - 1));

  // A config accept takes priority over every other exit, including a
  // simultaneous Rx_valid drop in RUN.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_SETTLE: if (w_settle_done) w_next = ST_LOCK;
      ST_LOCK: begin
        if (w_accept)       w_next = ST_DRAIN;
        else if (w_locked)  w_next = ST_RUN;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_RUN: begin
        if (w_accept)       w_next = ST_DRAIN;
        else if (!Rx_valid) w_next = ST_LOCK;
      end
      ST_DRAIN: if (frame_boundary(tx_valid, tx_data_tvalid, tx_data_tlast)) w_next = ST_APPLY;
      ST_APPLY: w_next = ST_SETTLE;
      ST_FAULT: w_next = w_accept ? ST_DRAIN : ST_SETTLE;
      default:  w_next = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_state      <= ST_SETTLE;
      r_settle_cnt <= '0;
      r_shadow     <= {DEF_MODE, DEF_DELAY, DEF_FB_SHIFT, DEF_GD_SHIFT, DEF_TX_PHASE};
      r_mode       <= DEF_MODE;
      r_delay      <= DEF_DELAY;
      r_fb         <= DEF_FB_SHIFT;
      r_gd         <= DEF_GD_SHIFT;
      r_phase      <= DEF_TX_PHASE;
      r_loss_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_shadow <= cfg_data;
      end
      // The only place the applied configuration ever changes.
      if (r_state == ST_APPLY) begin
        r_mode  <= r_shadow[CFG_MODE_LSB  +: CFG_NIB_W];
        r_delay <= r_shadow[CFG_DELAY_LSB +: CFG_NIB_W];
        r_fb    <= r_shadow[CFG_FB_LSB    +: CFG_NIB_W];
        r_gd    <= r_shadow[CFG_GD_LSB    +: CFG_NIB_W];
        r_phase <= r_shadow[CFG_PHASE_LSB +: CFG_PHASE_W];
      end
      if ((r_state == ST_RUN) && !w_accept && !Rx_valid && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

`ifdef LINK_CTRL_TIMEOUT_EN
  logic r_fault;

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_fault <= 1'b0;
    end else if ((r_state == ST_LOCK) && (w_next == ST_FAULT)) begin
      r_fault <= 1'b1;
    end else if (w_accept || (w_next == ST_RUN)) begin
      r_fault <= 1'b0;
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  assign MODE_CTRL       = r_mode;
  assign DELAY_CNT       = r_delay;
  assign FEEDBACK_SHIFT  = r_fb;
  assign GARDNER_SHIFT   = r_gd;
  assign TX_PHASE_CONFIG = r_phase;
  assign lock_loss_cnt   = r_loss_cnt;
  assign tx_enable       = (r_state == ST_RUN);
  assign link_up         = (r_state == ST_RUN);
  assign rx_flush        = (r_state == ST_SETTLE) || (r_state == ST_APPLY) || (r_state == ST_FAULT);

endmodule
